l2c_sram_sched: RTL and testbench
=================================

Name: l2c_sram_sched

Overview:
- Round-robin scheduler for the single L2C data-SRAM port.
- Serves four line-access engines: 0=read, 1=write, 2=fill, 3=writeback. Each has already resolved its tag lookup and presents a line-aligned SRAM address.
- Grants one engine at a time and drives a fixed-length burst on the SRAM.
- Gives each engine the i_start/i_end pulses its FSM waits on.

Parameters:
- BEATS, 8, beats per line burst; power of two, 2..8. Beat index occupies o_sram_adr[5:3].

Ports:
- Clk  in  1  clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- i_maintenance_active  in  1  when high, no new grant is issued; an in-flight burst completes.
- i_req  in  4  per-engine request; held high until that engine's o_end.
- i_req_adr  in  72  flat: engine n address at [18n+17:18n]; bits [5:0] ignored.
- i_req_we  in  4  per-engine direction: 1=write SRAM, 0=read SRAM.
- o_start  out  4  one-cycle pulse to the granted engine on the first beat.
- o_end  out  4  one-cycle pulse to the granted engine on the last beat.
- o_sram_ce  out  1  SRAM chip enable, high on every beat.
- o_sram_we  out  1  SRAM write enable, valid with o_sram_ce.
- o_sram_adr  out  18  {latched_adr[17:6], beat[2:0], 3'b000}.
- o_grant_id  out  2  id of the current or most recent grantee.
- o_sched_idle  out  1  high in Idle.

Behaviour:
- States: Idle, Burst, Gap. One-hot encoding.
- Reset values:
  - state = Idle.
  - All of o_start, o_end, o_sram_ce, o_sram_we are 0.
  - beat = 0, o_sram_adr = 0, o_grant_id = 0.
  - RR pointer ptr = 3, so engine 0 has top priority.
  - o_sched_idle = 1.
- Idle, when |i_req and ~i_maintenance_active:
  - Winner = first asserted request in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Latch the winner's address[17:6] and i_req_we bit.
  - o_grant_id = winner; ptr = winner; beat = 0; go to Burst.
  - Otherwise stay in Idle.
- Burst:
  - Every cycle: o_sram_ce=1, o_sram_we=latched we, o_sram_adr as defined above; beat increments.
  - o_start[g]=1 only when beat==0.
  - o_end[g]=1 only when beat==BEATS-1; leave to Gap that cycle.
  - When BEATS<8, unused high beat bits are 0.
- Gap:
  - One bus-turnaround cycle; all SRAM outputs 0; go to Idle.
  - Minimum grant-to-grant spacing is BEATS+2 cycles.
- Latency: request seen in Idle at cycle T gives first beat (o_start) at T+1 and o_end at T+BEATS.
- Registered outputs: all outputs are registered, or decoded from state/beat only. No combinational path from i_req to any output.
- Request withdrawal: a request dropped before its grant is simply not selected. A request dropped during its own Burst is ignored; the burst runs to completion.
- Maintenance: i_maintenance_active is sampled only in Idle. Asserting it during Burst/Gap does not truncate the burst.
- Simultaneous requests are resolved purely by RR order. Starvation bound: an asserted request is granted within 3 other bursts.
- Reset mid-burst: immediate return to reset values next cycle. No o_end is issued and ptr returns to 3.
- o_start and o_end are one-hot-or-zero and never target a non-granted engine. o_start and o_end coincide only if BEATS==1, which is illegal.

Test Plan:
- Reset, then i_req=4'b0001, adr 18'h1_2340, we=0 → o_start[0] at T+1, adr sequence 12340,12348,...,12378, o_end[0] at T+8, o_sram_we=0, o_sched_idle again at T+10.
- i_req=4'b1111 held → grant order 0,1,2,3,0; each burst 8 ce cycles plus 1 Gap; o_grant_id follows that order.
- After a grant to 2, i_req=4'b0101 → next grant is 0 (order 3,0,1,2); then 2.
- i_maintenance_active=1 with i_req=4'b0010 → no o_sram_ce for 20 cycles. Deassert → o_start[1] on the next cycle. Asserting maintenance at beat 3 → burst still ends with o_end[1].
- Reset at beat 4 of an engine-3 write burst → next cycle o_sram_ce=0 and no o_end. Then i_req=4'b1001 → engine 0 granted first.
- Engine 1 raises then drops i_req while engine 0 bursts, engine 2 requesting → engine 2 granted next and engine 1 never receives o_start.

Source files
------------

// File: rtl/l2c_sram_sched.sv
// Round-robin scheduler granting the single L2C data-SRAM port to one of four line engines.
// Grant registered one cycle after the request is seen, then a BEATS-long burst and one turnaround cycle.
module l2c_sram_sched #(
  parameter int BEATS = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_maintenance_active,
  input  logic [3:0]  i_req,
  input  logic [71:0] i_req_adr,
  input  logic [3:0]  i_req_we,
  output logic [3:0]  o_start,
  output logic [3:0]  o_end,
  output logic        o_sram_ce,
  output logic        o_sram_we,
  output logic [17:0] o_sram_adr,
  output logic [1:0]  o_grant_id,
  output logic        o_sched_idle
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    BURST = 3'b010,
    GAP   = 3'b100
  } state_t;

  localparam logic [2:0] LAST = 3'(BEATS - 1);

  state_t      state_q;
  logic [2:0]  beat_q;
  logic [1:0]  ptr_q;
  logic [11:0] adr_q;
  logic        we_q;

  logic        win_vld;
  logic [1:0]  win_id;
  logic [1:0]  cand;
  logic [17:0] win_adr;
  logic [2:0]  beat_nxt;

  // Walk from lowest to highest priority so the last hit is the RR winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ptr_q;
    cand    = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (i_req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  always_comb begin
    win_adr = 18'd0;
    for (int n = 0; n < 4; n++) begin
      if (win_id == 2'(n)) win_adr = i_req_adr[18*n +: 18];
    end
  end

  assign beat_nxt     = beat_q + 3'd1;
  assign o_sched_idle = (state_q == IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      beat_q     <= 3'd0;
      ptr_q      <= 2'd3;
      adr_q      <= 12'd0;
      we_q       <= 1'b0;
      o_start    <= 4'd0;
      o_end      <= 4'd0;
      o_sram_ce  <= 1'b0;
      o_sram_we  <= 1'b0;
      o_sram_adr <= 18'd0;
      o_grant_id <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld && !i_maintenance_active) begin
            state_q    <= BURST;
            ptr_q      <= win_id;
            o_grant_id <= win_id;
            adr_q      <= win_adr[17:6];
            we_q       <= i_req_we[win_id];
            beat_q     <= 3'd0;
            o_sram_ce  <= 1'b1;
            o_sram_we  <= i_req_we[win_id];
            o_sram_adr <= {win_adr[17:6], 6'd0};
            o_start    <= 4'b0001 << win_id;
            o_end      <= 4'd0;
          end
        end
        BURST: begin
          if (beat_q == LAST) begin
            state_q    <= GAP;
            o_start    <= 4'd0;
            o_end      <= 4'd0;
            o_sram_ce  <= 1'b0;
            o_sram_we  <= 1'b0;
            o_sram_adr <= 18'd0;
          end else begin
            beat_q     <= beat_nxt;
            o_sram_ce  <= 1'b1;
            o_sram_we  <= we_q;
            o_sram_adr <= {adr_q, beat_nxt, 3'b000};
            o_start    <= 4'd0;
            o_end      <= (beat_nxt == LAST) ? (4'b0001 << o_grant_id) : 4'd0;
          end
        end
        GAP: begin
          state_q <= IDLE;
          beat_q  <= 3'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2c_sram_sched.sv
// Directed bench for l2c_sram_sched: table of RR grant scenarios plus hand-written corner sequences.
module tb_l2c_sram_sched;

  localparam int BEATS = 8;

  logic        Clk;
  logic        Reset;
  logic        i_maintenance_active;
  logic [3:0]  i_req;
  logic [71:0] i_req_adr;
  logic [3:0]  i_req_we;
  logic [3:0]  o_start;
  logic [3:0]  o_end;
  logic        o_sram_ce;
  logic        o_sram_we;
  logic [17:0] o_sram_adr;
  logic [1:0]  o_grant_id;
  logic        o_sched_idle;

  int checks = 0;
  int errors = 0;

  logic [17:0] adr_tab [4];
  logic [3:0]  we_vec;

  typedef struct {
    logic [3:0] req;
    logic [3:0] req_end;
    logic [1:0] id;
    int         wait_c;
  } vec_t;

  vec_t tab [8];

  l2c_sram_sched #(.BEATS(BEATS)) dut (
    .Clk                  (Clk),
    .Reset                (Reset),
    .i_maintenance_active (i_maintenance_active),
    .i_req                (i_req),
    .i_req_adr            (i_req_adr),
    .i_req_we             (i_req_we),
    .o_start              (o_start),
    .o_end                (o_end),
    .o_sram_ce            (o_sram_ce),
    .o_sram_we            (o_sram_we),
    .o_sram_adr           (o_sram_adr),
    .o_grant_id           (o_grant_id),
    .o_sched_idle         (o_sched_idle)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    i_req = 4'd0;
    i_maintenance_active = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Waits for o_start, then checks every beat of one burst from engine id.
  task automatic burst(input logic [1:0] id, input int exp_wait, input logic [3:0] req_end,
                       input int hook_beat, input logic [3:0] hook_req,
                       input int maint_beat, input int rst_beat);
    int          n;
    logic [17:0] base;
    logic [17:0] ea;
    logic [3:0]  es;
    logic [3:0]  ee;
    n = 0;
    while (o_start == 4'd0 && n < 40) begin
      @(negedge Clk);
      n++;
      if (o_start == 4'd0) chk("ce_before_start", 32'(o_sram_ce), 32'd0);
    end
    chk("start_latency", 32'(n), 32'(exp_wait));
    base = adr_tab[id];
    for (int b = 0; b < BEATS; b++) begin
      ea = {base[17:6], 3'(b), 3'b000};
      es = (b == 0) ? (4'b0001 << id) : 4'd0;
      ee = (b == BEATS - 1) ? (4'b0001 << id) : 4'd0;
      chk("beat_ce",    32'(o_sram_ce),    32'd1);
      chk("beat_we",    32'(o_sram_we),    32'(we_vec[id]));
      chk("beat_adr",   32'(o_sram_adr),   32'(ea));
      chk("beat_gid",   32'(o_grant_id),   32'(id));
      chk("beat_idle",  32'(o_sched_idle), 32'd0);
      chk("beat_start", 32'(o_start),      32'(es));
      chk("beat_end",   32'(o_end),        32'(ee));
      if (b == hook_beat) i_req = hook_req;
      if (b == maint_beat) i_maintenance_active = 1'b1;
      if (b == rst_beat) begin
        Reset = 1'b1;
        return;
      end
      if (b == BEATS - 1) i_req = req_end;
      else @(negedge Clk);
    end
  endtask

  initial begin
    adr_tab[0] = 18'h1_2340;
    adr_tab[1] = 18'h2_0a7f;
    adr_tab[2] = 18'h3_ffc0;
    adr_tab[3] = 18'h0_0055;
    we_vec     = 4'b1010;
    i_req_adr  = {adr_tab[3], adr_tab[2], adr_tab[1], adr_tab[0]};
    i_req_we   = we_vec;

    tab[0] = '{req: 4'b1111, req_end: 4'b1111, id: 2'd0, wait_c: 1};
    tab[1] = '{req: 4'b1111, req_end: 4'b1111, id: 2'd1, wait_c: 3};
    tab[2] = '{req: 4'b1111, req_end: 4'b1111, id: 2'd2, wait_c: 3};
    tab[3] = '{req: 4'b1111, req_end: 4'b1111, id: 2'd3, wait_c: 3};
    tab[4] = '{req: 4'b1111, req_end: 4'b0100, id: 2'd0, wait_c: 3};
    tab[5] = '{req: 4'b0100, req_end: 4'b0101, id: 2'd2, wait_c: 3};
    tab[6] = '{req: 4'b0101, req_end: 4'b0101, id: 2'd0, wait_c: 3};
    tab[7] = '{req: 4'b0101, req_end: 4'b0000, id: 2'd2, wait_c: 3};

    Reset = 1'b1;
    i_req = 4'd0;
    i_maintenance_active = 1'b0;
    do_reset();
    chk("rst_ce",    32'(o_sram_ce),    32'd0);
    chk("rst_we",    32'(o_sram_we),    32'd0);
    chk("rst_adr",   32'(o_sram_adr),   32'd0);
    chk("rst_gid",   32'(o_grant_id),   32'd0);
    chk("rst_start", 32'(o_start),      32'd0);
    chk("rst_end",   32'(o_end),        32'd0);
    chk("rst_idle",  32'(o_sched_idle), 32'd1);

    // Single read burst: start at T+1, end at T+8, Gap, Idle at T+10.
    i_req = 4'b0001;
    burst(2'd0, 1, 4'b0000, -1, 4'd0, -1, -1);
    @(negedge Clk);
    chk("gap_ce",   32'(o_sram_ce),    32'd0);
    chk("gap_end",  32'(o_end),        32'd0);
    chk("gap_idle", 32'(o_sched_idle), 32'd0);
    @(negedge Clk);
    chk("idle_back", 32'(o_sched_idle), 32'd1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      i_req = tab[i].req;
      burst(tab[i].id, tab[i].wait_c, tab[i].req_end, -1, 4'd0, -1, -1);
    end

    // Maintenance blocks new grants but not an in-flight burst.
    @(negedge Clk);
    @(negedge Clk);
    i_maintenance_active = 1'b1;
    i_req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      chk("maint_no_ce",   32'(o_sram_ce),    32'd0);
      chk("maint_idle",    32'(o_sched_idle), 32'd1);
    end
    i_maintenance_active = 1'b0;
    burst(2'd1, 1, 4'b0000, -1, 4'd0, 3, -1);
    @(negedge Clk);
    @(negedge Clk);
    chk("maint_idle_after", 32'(o_sched_idle), 32'd1);
    i_maintenance_active = 1'b0;

    // Reset at beat 4 of an engine-3 writeback burst.
    i_req = 4'b1000;
    burst(2'd3, 1, 4'b0000, -1, 4'd0, -1, 4);
    @(negedge Clk);
    chk("midrst_ce",    32'(o_sram_ce),    32'd0);
    chk("midrst_we",    32'(o_sram_we),    32'd0);
    chk("midrst_end",   32'(o_end),        32'd0);
    chk("midrst_start", 32'(o_start),      32'd0);
    chk("midrst_adr",   32'(o_sram_adr),   32'd0);
    chk("midrst_gid",   32'(o_grant_id),   32'd0);
    chk("midrst_idle",  32'(o_sched_idle), 32'd1);
    Reset = 1'b0;
    i_req = 4'b1001;
    burst(2'd0, 1, 4'b0000, -1, 4'd0, -1, -1);

    // Engine 1 raises then drops its request while engine 0 bursts.
    i_req = 4'b0001;
    burst(2'd0, 3, 4'b0100, 2, 4'b0111, -1, -1);
    burst(2'd2, 3, 4'b0000, -1, 4'd0, -1, -1);
    @(negedge Clk);
    @(negedge Clk);
    chk("final_idle", 32'(o_sched_idle), 32'd1);
    chk("final_ce",   32'(o_sram_ce),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
